// File: rtl/reservoir_pkg.sv
// Shared types and default sizing for the reservoir node chain and the blocks that observe it.
package reservoir_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH = 32;
    localparam int unsigned DEFAULT_NUM_NODES  = 50;

    typedef enum logic [1:0] {
        CAP_IDLE,
        CAP_CAPTURE,
        CAP_DRAIN
    } cap_state_t;

    // Index width for n entries, never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/reservoir_sample_buffer.sv
// Register-file holding one capture of virtual-node states: one write port, one async read port.
import reservoir_pkg::*;

module reservoir_sample_buffer #(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned NUM_NODES  = DEFAULT_NUM_NODES,
    parameter int unsigned IDX_WIDTH  = idx_width(NUM_NODES)
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [IDX_WIDTH-1:0]  wr_idx,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [IDX_WIDTH-1:0]  rd_idx,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem_q [NUM_NODES];

    // Decoded per-entry compare keeps the index width independent of the entry count.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < NUM_NODES; i++) begin
            if (wr_en && (wr_idx == IDX_WIDTH'(i))) begin
                mem_q[i] <= wr_data;
            end
        end
    end

    always_comb begin
        rd_data = '0;
        for (int unsigned i = 0; i < NUM_NODES; i++) begin
            if (rd_idx == IDX_WIDTH'(i)) begin
                rd_data = mem_q[i];
            end
        end
    end

endmodule

// File: rtl/reservoir_state_capture.sv
// Samples the tap node once per chain shift strobe, buffers one full set of virtual-node
// states and streams them out over valid/ready.
import reservoir_pkg::*;

module reservoir_state_capture #(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned NUM_NODES  = DEFAULT_NUM_NODES,
    localparam int unsigned IDX_WIDTH = idx_width(NUM_NODES)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  sample_en,
    input  logic [DATA_WIDTH-1:0] node_dout,
    output logic                  busy,
    output logic                  done,
    output logic                  missed,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [IDX_WIDTH-1:0]  m_index,
    output logic                  m_last
);

    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_NODES - 1);

    cap_state_t            state_q, state_d;
    logic [IDX_WIDTH-1:0]  wr_idx_q, wr_idx_d;
    logic [IDX_WIDTH-1:0]  rd_idx_q, rd_idx_d;
    logic                  missed_q, missed_d;
    logic                  done_q, done_d;
    logic                  wr_en;
    logic                  draining;
    logic                  beat;
    logic                  at_last;
    logic [DATA_WIDTH-1:0] rd_data;

    assign draining = (state_q == CAP_DRAIN);
    assign at_last  = (rd_idx_q == LAST_IDX);
    assign beat     = draining && m_ready;
    assign wr_en    = (state_q == CAP_CAPTURE) && sample_en;

    reservoir_sample_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_NODES  (NUM_NODES),
        .IDX_WIDTH  (IDX_WIDTH)
    ) u_buf (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_idx  (wr_idx_q),
        .wr_data (node_dout),
        .rd_idx  (rd_idx_q),
        .rd_data (rd_data)
    );

    always_comb begin
        state_d  = state_q;
        wr_idx_d = wr_idx_q;
        rd_idx_d = rd_idx_q;
        missed_d = missed_q;
        done_d   = 1'b0;
        unique case (state_q)
            CAP_IDLE: begin
                // A strobe coinciding with start belongs to no capture yet.
                if (start) begin
                    state_d  = CAP_CAPTURE;
                    wr_idx_d = '0;
                    missed_d = 1'b0;
                end
            end
            CAP_CAPTURE: begin
                if (sample_en) begin
                    if (wr_idx_q == LAST_IDX) begin
                        state_d  = CAP_DRAIN;
                        rd_idx_d = '0;
                    end else begin
                        wr_idx_d = wr_idx_q + IDX_WIDTH'(1);
                    end
                end
            end
            CAP_DRAIN: begin
                if (sample_en) begin
                    missed_d = 1'b1;
                end
                if (beat) begin
                    if (at_last) begin
                        state_d = CAP_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        rd_idx_d = rd_idx_q + IDX_WIDTH'(1);
                    end
                end
            end
            default: state_d = CAP_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= CAP_IDLE;
            wr_idx_q <= '0;
            rd_idx_q <= '0;
            missed_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_idx_q <= wr_idx_d;
            rd_idx_q <= rd_idx_d;
            missed_q <= missed_d;
            done_q   <= done_d;
        end
    end

    // Payload is forced to zero outside DRAIN so stale buffer contents never leak out.
    assign busy    = (state_q != CAP_IDLE);
    assign done    = done_q;
    assign missed  = missed_q;
    assign m_valid = draining;
    assign m_data  = draining ? rd_data : '0;
    assign m_index = draining ? rd_idx_q : '0;
    assign m_last  = draining && at_last;

    a_hold_until_accepted: assert property (@(posedge clk) disable iff (rst)
        (m_valid && !m_ready) |=> (m_valid && $stable(m_data) && $stable(m_index)
                                   && $stable(m_last)));

    a_idx_in_range: assert property (@(posedge clk) disable iff (rst)
        (wr_idx_q <= LAST_IDX) && (rd_idx_q <= LAST_IDX));

endmodule

// File: doc/reservoir_state_capture.md
# reservoir_state_capture

Reader side of the delay-feedback reservoir node chain. Samples the output of a tap node once per chain shift strobe, buffers one full set of `NUM_NODES` virtual-node states and streams them out over a valid/ready interface to the readout/output layer or host DMA. It sits beside the node chain and observes the same `en` strobe the chain uses to shift. It never drives the nodes.

## Interface
- `DATA_WIDTH`, 32, width of one node state word.
- `NUM_NODES`, 50, virtual nodes per capture; legal range ≥1.
- `IDX_WIDTH`, `$clog2(NUM_NODES)` (minimum 1), derived width of index and counters.

- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `start` in 1: single-cycle request to begin a capture; accepted only in IDLE.
- `sample_en` in 1: chain shift strobe, the same signal as the nodes' `en`.
- `node_dout` in `DATA_WIDTH`: tap node output, sampled when `sample_en`=1.
- `busy` out 1: high in CAPTURE and DRAIN.
- `done` out 1: one-cycle pulse after the last beat is accepted.
- `missed` out 1: sticky flag; `sample_en` was seen while in DRAIN. Cleared by an accepted `start` or by reset.
- `m_valid` out 1: output word valid.
- `m_ready` in 1: consumer ready.
- `m_data` out `DATA_WIDTH`: node state word.
- `m_index` out `IDX_WIDTH`: node number of `m_data`, from 0 to `NUM_NODES`-1.
- `m_last` out 1: high with the beat where `m_index`=`NUM_NODES`-1.

## Operation
- **States:** IDLE, CAPTURE, DRAIN.
- **IDLE:**
  - `start`=1 → CAPTURE; `wr_idx`←0; `missed`←0.
  - `sample_en` is ignored in IDLE, including when it arrives in the same cycle as `start`.
- **CAPTURE:**
  - Each cycle with `sample_en`=1 writes `node_dout` to `buf[wr_idx]` and increments `wr_idx`.
  - On the write where `wr_idx`=`NUM_NODES`-1: → DRAIN; `rd_idx`←0.
  - `start` is ignored.
- **DRAIN:**
  - `m_valid`=1.
  - `m_data`=`buf[rd_idx]`, `m_index`=`rd_idx`, `m_last`=(`rd_idx`==`NUM_NODES`-1).
  - When `m_valid`&&`m_ready`: `rd_idx` increments. If `m_last` was high on that beat: → IDLE and `done` pulses.
  - `sample_en` in DRAIN sets `missed`; no data is written.
- **Handshake rules:**
  - Once `m_valid` is high, `m_data`, `m_index` and `m_last` stay stable until accepted.
  - `m_valid` never drops before acceptance.
  - `m_ready` may toggle freely.
- **Counters:** `wr_idx` and `rd_idx` never wrap past `NUM_NODES`-1. There is no modular arithmetic.
- **Reset (including mid-capture or mid-drain):** → IDLE. All outputs 0: `busy`, `done`, `missed`, `m_valid`, `m_data`, `m_index`, `m_last`. Buffer contents are don't-care.

## Timing
- **Start:** `start` at cycle t (IDLE) → `busy`=1 from t+1. The first sample is accepted at t+1 or later.
- **Sampling:** a sample taken at cycle c captures `node_dout` as seen at cycle c, i.e. the value before the chain shift lands.
- **Capture to drain:** last sample at cycle c → `m_valid`=1 at c+1 with `m_index`=0. With `NUM_NODES`=1, `m_data` at c+1 equals the word sampled at c (buffer write visible next cycle).
- **Throughput:** one beat per cycle while `m_ready`=1. `NUM_NODES` beats with `m_ready` held high take exactly `NUM_NODES` cycles.
- **End of drain:** last beat accepted at cycle d → at d+1: `m_valid`=0, `busy`=0, `done`=1 (for one cycle). A `start` at d+1 is accepted.
- **Back-to-back:** `start` at d+1 → `busy` high again at d+2.

## Structure
- **Shared package `reservoir_pkg`:** holds `typedef enum logic [1:0] {CAP_IDLE, CAP_CAPTURE, CAP_DRAIN} cap_state_t`, and the default `DATA_WIDTH` / `NUM_NODES` constants shared with the node chain.
- **Sub-module `reservoir_sample_buffer`:** register-file storage with one write port and one asynchronous read port, parameterized by `DATA_WIDTH` and `NUM_NODES`. The FSM, counters and handshake stay in the top module.

## Test plan
- **Basic capture (`NUM_NODES`=4):** `start`; `sample_en` on 4 consecutive cycles with `node_dout` = 0x11, 0x22, 0x33, 0x44; `m_ready`=1 → beats 0x11..0x44 with `m_index` 0..3; `m_last` only on 0x44; `done` one cycle after the 0x44 beat; `busy` drops the same cycle as `done`.
- **Gapped sampling and backpressure:** `sample_en` every 3rd cycle; `m_ready` pattern 1,0,0,1,0,1,1 → output order and data unchanged; `m_data` stable on every stall cycle.
- **Ignored inputs:** `sample_en`=1 in IDLE and in the same cycle as `start` → not captured (first beat = first strobe after `start`). `start` mid-CAPTURE → no restart, `wr_idx` unaffected.
- **Missed samples:** `sample_en` pulses during DRAIN → `missed`=1 and stays 1 after `done`; next accepted `start` → `missed`=0; drained data uncorrupted.
- **Reset mid-drain:** `rst` for one cycle after 2 of 4 beats → next cycle all outputs 0, IDLE; a following full capture of 0xA0..0xA3 drains correctly.
- **Edge sizes:** `NUM_NODES`=1 → single beat, `m_last`=1, `m_index`=0, `m_data` equals the sample taken the previous cycle. Back-to-back captures with `start` on the `done` cycle → no lost or duplicated beats.
